// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer: one access in flight, SRAM-like split
// address/data handshake, store lane steering and alignment exceptions.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_rtdata,
  input  logic [4:0]  in_dest,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_opcode,
  output logic [1:0]  out_ea,
  output logic [31:0] out_regdata,
  output logic [31:0] out_loadin,
  output logic [4:0]  out_dest,
  output logic        out_is_load,
  output logic [1:0]  out_exc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [5:0] OP_LB  = 6'd32;
  localparam logic [5:0] OP_LH  = 6'd33;
  localparam logic [5:0] OP_LWL = 6'd34;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_LBU = 6'd36;
  localparam logic [5:0] OP_LHU = 6'd37;
  localparam logic [5:0] OP_LWR = 6'd38;
  localparam logic [5:0] OP_SB  = 6'd40;
  localparam logic [5:0] OP_SH  = 6'd41;
  localparam logic [5:0] OP_SWL = 6'd42;
  localparam logic [5:0] OP_SW  = 6'd43;
  localparam logic [5:0] OP_SWR = 6'd46;

  function automatic logic is_load_op(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: is_load_op = 1'b1;
      default:                                             is_load_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: is_store_op = 1'b1;
      default:                             is_store_op = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] size_of(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: size_of = 2'd0;
      OP_LH, OP_LHU, OP_SH: size_of = 2'd1;
      default:              size_of = 2'd2;
    endcase
  endfunction

  // lwl/lwr/swl/swr are unaligned by design and never trap
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] ea);
    case (op)
      OP_LH, OP_LHU, OP_SH: misaligned = ea[0];
      OP_LW, OP_SW:         misaligned = (ea != 2'd0);
      default:              misaligned = 1'b0;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rt_q, rt_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] loadin_q, loadin_d;
  logic [1:0]  exc_q, exc_d;

  logic [3:0]  strobe_s;
  logic [31:0] lane_data_s;

  // State and latched-field registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      opcode_q <= 6'd0;
      addr_q   <= 32'd0;
      rt_q     <= 32'd0;
      dest_q   <= 5'd0;
      loadin_q <= 32'd0;
      exc_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      addr_q   <= addr_d;
      rt_q     <= rt_d;
      dest_q   <= dest_d;
      loadin_q <= loadin_d;
      exc_q    <= exc_d;
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    addr_d   = addr_q;
    rt_d     = rt_q;
    dest_d   = dest_q;
    loadin_d = loadin_q;
    exc_d    = exc_q;
    case (state_q)
      IDLE: begin
        if (in_valid && (is_load_op(in_opcode) || is_store_op(in_opcode))) begin
          opcode_d = in_opcode;
          addr_d   = in_addr;
          rt_d     = in_rtdata;
          dest_d   = in_dest;
          loadin_d = 32'd0;
          if (misaligned(in_opcode, in_addr[1:0])) begin
            state_d = RESP;
            exc_d   = is_load_op(in_opcode) ? 2'd1 : 2'd2;
          end else begin
            state_d = ADDR;
            exc_d   = 2'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (data_addr_ok) begin
          state_d = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (data_data_ok) begin
          state_d  = RESP;
          loadin_d = is_load_op(opcode_q) ? data_rdata : 32'd0;
        end else begin
          state_d = DATA;
        end
      end
      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Store byte-lane steering from the latched opcode, ea and rt
  always_comb begin
    strobe_s    = 4'b0000;
    lane_data_s = 32'd0;
    case (opcode_q)
      OP_SB: begin
        strobe_s    = 4'b0001 << addr_q[1:0];
        lane_data_s = {4{rt_q[7:0]}};
      end
      OP_SH: begin
        strobe_s    = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data_s = {2{rt_q[15:0]}};
      end
      OP_SW: begin
        strobe_s    = 4'b1111;
        lane_data_s = rt_q;
      end
      OP_SWL: begin
        case (addr_q[1:0])
          2'd0:    begin strobe_s = 4'b0001; lane_data_s = {24'd0, rt_q[31:24]}; end
          2'd1:    begin strobe_s = 4'b0011; lane_data_s = {16'd0, rt_q[31:16]}; end
          2'd2:    begin strobe_s = 4'b0111; lane_data_s = {8'd0, rt_q[31:8]};   end
          default: begin strobe_s = 4'b1111; lane_data_s = rt_q;                 end
        endcase
      end
      OP_SWR: begin
        case (addr_q[1:0])
          2'd0:    begin strobe_s = 4'b1111; lane_data_s = rt_q;                 end
          2'd1:    begin strobe_s = 4'b1110; lane_data_s = {rt_q[23:0], 8'd0};   end
          2'd2:    begin strobe_s = 4'b1100; lane_data_s = {rt_q[15:0], 16'd0};  end
          default: begin strobe_s = 4'b1000; lane_data_s = {rt_q[7:0], 24'd0};   end
        endcase
      end
      default: begin
        strobe_s    = 4'b0000;
        lane_data_s = 32'd0;
      end
    endcase
  end

  // Bus and result outputs decoded from the registered state
  always_comb begin
    in_ready  = (state_q == IDLE) & resetn;
    data_req  = (state_q == ADDR);
    data_addr = {addr_q[31:2], 2'b00};
    if (state_q == ADDR) begin
      data_wr    = is_store_op(opcode_q);
      data_size  = size_of(opcode_q);
      data_wstrb = strobe_s;
      data_wdata = lane_data_s;
    end else begin
      data_wr    = 1'b0;
      data_size  = 2'd0;
      data_wstrb = 4'b0000;
      data_wdata = 32'd0;
    end
    out_valid   = (state_q == RESP);
    out_opcode  = opcode_q;
    out_ea      = addr_q[1:0];
    out_regdata = rt_q;
    out_loadin  = loadin_q;
    out_dest    = dest_q;
    out_is_load = is_load_op(opcode_q);
    out_exc     = exc_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; inputs change 1 time unit
// after each rising edge and outputs are checked in that same quiet window.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [31:0] in_addr;
  logic [31:0] in_rtdata;
  logic [4:0]  in_dest;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [1:0]  out_ea;
  logic [31:0] out_regdata;
  logic [31:0] out_loadin;
  logic [4:0]  out_dest;
  logic        out_is_load;
  logic [1:0]  out_exc;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_addr      (in_addr),
    .in_rtdata    (in_rtdata),
    .in_dest      (in_dest),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_rdata   (data_rdata),
    .data_data_ok (data_data_ok),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_ea       (out_ea),
    .out_regdata  (out_regdata),
    .out_loadin   (out_loadin),
    .out_dest     (out_dest),
    .out_is_load  (out_is_load),
    .out_exc      (out_exc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] rt, input logic [4:0] d);
    in_valid  = 1'b1;
    in_opcode = op;
    in_addr   = a;
    in_rtdata = rt;
    in_dest   = d;
    step();
    in_valid  = 1'b0;
    in_opcode = 6'd0;
    #1;
  endtask

  // addr_ok then data_ok in their first eligible cycles; ends in RESP
  task automatic complete(input logic [31:0] rd);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = rd;
    step();
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
    #1;
  endtask

  task automatic release_resp();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_opcode = 6'd0; in_addr = 32'd0;
    in_rtdata = 32'd0; in_dest = 5'd0; data_addr_ok = 1'b0;
    data_rdata = 32'd0; data_data_ok = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 32'd0);
    chk("rst_req", data_req, 32'd0);
    chk("rst_wr", data_wr, 32'd0);
    chk("rst_wstrb", data_wstrb, 32'd0);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_exc", out_exc, 32'd0);
    chk("rst_is_load", out_is_load, 32'd0);
    chk("rst_opcode", out_opcode, 32'd0);
    chk("rst_loadin", out_loadin, 32'd0);
    resetn = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 32'd1);

    // lw 0x1000 with addr_ok delayed two cycles
    accept(6'd35, 32'h0000_1000, 32'h0000_5555, 5'd7);
    for (int i = 0; i < 3; i++) begin
      chk("lw_req", data_req, 32'd1);
      chk("lw_addr", data_addr, 32'h0000_1000);
      chk("lw_size", data_size, 32'd2);
      chk("lw_wr", data_wr, 32'd0);
      chk("lw_wstrb", data_wstrb, 32'd0);
      chk("lw_in_ready", in_ready, 32'd0);
      if (i == 2) data_addr_ok = 1'b1;
      step();
    end
    data_addr_ok = 1'b0;
    #1;
    chk("lw_data_req", data_req, 32'd0);
    chk("lw_data_valid", out_valid, 32'd0);
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEAD_BEEF;
    step();
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
    #1;
    chk("lw_out_valid", out_valid, 32'd1);
    chk("lw_loadin", out_loadin, 32'hDEAD_BEEF);
    chk("lw_ea", out_ea, 32'd0);
    chk("lw_is_load", out_is_load, 32'd1);
    chk("lw_dest", out_dest, 32'd7);
    chk("lw_regdata", out_regdata, 32'h0000_5555);
    chk("lw_exc", out_exc, 32'd0);
    release_resp();
    chk("lw_idle_valid", out_valid, 32'd0);
    chk("lw_idle_ready", in_ready, 32'd1);

    // Unsupported opcode is dropped
    accept(6'd0, 32'h0000_0100, 32'd0, 5'd1);
    chk("bad_op_ready", in_ready, 32'd1);
    chk("bad_op_req", data_req, 32'd0);
    chk("bad_op_valid", out_valid, 32'd0);

    // sb 0x2003; a stray data_ok in ADDR must not advance
    accept(6'd40, 32'h0000_2003, 32'h0000_00A5, 5'd0);
    chk("sb_req", data_req, 32'd1);
    chk("sb_wr", data_wr, 32'd1);
    chk("sb_wstrb", data_wstrb, 32'b1000);
    chk("sb_wdata", data_wdata, 32'hA5A5_A5A5);
    chk("sb_size", data_size, 32'd0);
    chk("sb_addr", data_addr, 32'h0000_2000);
    data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    #1;
    chk("sb_stray_dok", data_req, 32'd1);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    #1;
    chk("sb_data_wdata0", data_wdata, 32'd0);
    chk("sb_data_wstrb0", data_wstrb, 32'd0);
    data_data_ok = 1'b1;
    data_rdata   = 32'hFFFF_FFFF;
    step();
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
    #1;
    chk("sb_out_valid", out_valid, 32'd1);
    chk("sb_is_load", out_is_load, 32'd0);
    chk("sb_loadin", out_loadin, 32'd0);
    chk("sb_ea", out_ea, 32'd3);
    release_resp();

    // swl / swr at ea 1
    accept(6'd42, 32'h0000_3001, 32'h1122_3344, 5'd0);
    chk("swl_wstrb", data_wstrb, 32'b0011);
    chk("swl_wdata", data_wdata, 32'h0000_1122);
    chk("swl_size", data_size, 32'd2);
    complete(32'd0);
    chk("swl_out_valid", out_valid, 32'd1);
    release_resp();
    accept(6'd46, 32'h0000_3001, 32'h1122_3344, 5'd0);
    chk("swr_wstrb", data_wstrb, 32'b1110);
    chk("swr_wdata", data_wdata, 32'h2233_4400);
    complete(32'd0);
    chk("swr_out_valid", out_valid, 32'd1);
    release_resp();

    // Misaligned lh and sw skip the bus
    accept(6'd33, 32'h0000_4001, 32'd0, 5'd3);
    chk("lh_mis_req", data_req, 32'd0);
    chk("lh_mis_valid", out_valid, 32'd1);
    chk("lh_mis_exc", out_exc, 32'd1);
    chk("lh_mis_is_load", out_is_load, 32'd1);
    release_resp();
    accept(6'd43, 32'h0000_4002, 32'h0BAD_F00D, 5'd0);
    chk("sw_mis_req", data_req, 32'd0);
    chk("sw_mis_valid", out_valid, 32'd1);
    chk("sw_mis_exc", out_exc, 32'd2);
    chk("sw_mis_is_load", out_is_load, 32'd0);
    release_resp();

    // Reset in DATA abandons the lwr; late data_ok is ignored
    accept(6'd38, 32'h0000_5002, 32'hAAAA_5555, 5'd4);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    #1;
    chk("lwr_in_data", data_req, 32'd0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'h1234_5678;
    #1;
    chk("lwr_rst_ready", in_ready, 32'd1);
    step();
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
    #1;
    chk("lwr_rst_valid", out_valid, 32'd0);
    chk("lwr_rst_req", data_req, 32'd0);
    chk("lwr_rst_loadin", out_loadin, 32'd0);
    chk("lwr_rst_opcode", out_opcode, 32'd0);
    chk("lwr_rst_ready2", in_ready, 32'd1);

    // RESP backpressure with a pending request on the input
    accept(6'd32, 32'h0000_6002, 32'h0000_0011, 5'd12);
    complete(32'hCAFE_F00D);
    in_valid  = 1'b1;
    in_opcode = 6'd36;
    in_addr   = 32'h0000_7001;
    in_rtdata = 32'd0;
    in_dest   = 5'd9;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", out_valid, 32'd1);
      chk("bp_loadin", out_loadin, 32'hCAFE_F00D);
      chk("bp_opcode", out_opcode, 32'd32);
      chk("bp_ea", out_ea, 32'd2);
      chk("bp_dest", out_dest, 32'd12);
      chk("bp_in_ready", in_ready, 32'd0);
      chk("bp_req", data_req, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    chk("bp_idle_ready", in_ready, 32'd1);
    chk("bp_idle_req", data_req, 32'd0);
    chk("bp_idle_valid", out_valid, 32'd0);
    step();
    in_valid = 1'b0;
    #1;
    chk("bp_next_req", data_req, 32'd1);
    chk("bp_next_addr", data_addr, 32'h0000_7000);
    chk("bp_next_size", data_size, 32'd0);
    chk("bp_next_wstrb", data_wstrb, 32'd0);
    complete(32'h0000_00F0);
    chk("bp_next_loadin", out_loadin, 32'h0000_00F0);
    chk("bp_next_ea", out_ea, 32'd1);
    chk("bp_next_dest", out_dest, 32'd9);
    release_resp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage load/store sequencer for the 5-stage pipeline. Accepts one memory instruction at a time from EX, issues the request on the SRAM-like data bus, and waits for the address and data handshakes. It then presents opcode, effective-address low bits, the old rt value and the raw read word to the load-data aligner and WB. It also generates store byte strobes and lane-replicated write data, detects misalignment, and holds the pipeline while an access is outstanding.

## Interface
Parameters: none.

Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock; all state changes on its rising edge.
- resetn  in  1  synchronous active-low reset.

EX-side input:
- in_valid  in  1  EX holds a valid instruction.
- in_ready  out  1  controller can accept; equals (state==IDLE) & resetn.
- in_opcode  in  6  MIPS primary opcode.
- in_addr  in  32  effective address.
- in_rtdata  in  32  rt register value (store data / lwl/lwr merge source).
- in_dest  in  5  destination register number.

Data bus:
- data_req  out  1  request valid.
- data_wr  out  1  1 = write.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  always {addr[31:2],2'b00}.
- data_wstrb  out  4  byte enables; 0 for loads.
- data_wdata  out  32  lane-aligned write data.
- data_addr_ok  in  1  request accepted.
- data_rdata  in  32  read word.
- data_data_ok  in  1  read/write completion.

WB / aligner output:
- out_valid  out  1  result valid.
- out_ready  in  1  WB accepts.
- out_opcode  out  6  latched opcode.
- out_ea  out  2  latched addr[1:0].
- out_regdata  out  32  latched rt.
- out_loadin  out  32  captured data_rdata (0 for stores).
- out_dest  out  5  latched dest.
- out_is_load  out  1  opcode ∈ {32,33,34,35,36,37,38}.
- out_exc  out  2  0 = none, 1 = AdEL, 2 = AdES.

## Operation
Opcode decode:
- Loads: lb 32, lh 33, lwl 34, lw 35, lbu 36, lhu 37, lwr 38.
- Stores: sb 40, sh 41, swl 42, sw 43, swr 46.
- Any other opcode accepted in IDLE is discarded: no bus activity, no out_valid.

States: IDLE, ADDR, DATA, RESP.
- IDLE → ADDR on in_valid: latch all in_* fields.
- IDLE → RESP directly if misaligned: lh/lhu/sh with ea[0]=1, or lw/sw with ea≠0. out_exc is 1 for the load opcodes, 2 for sh/sw.
- ADDR: data_req=1. data_wr/size/addr/wstrb/wdata are held stable until data_addr_ok. On data_addr_ok → DATA.
- DATA: data_req=0. On data_data_ok, capture data_rdata into out_loadin (loads only) → RESP.
- RESP: out_valid=1 with all out_* fields stable. On out_ready → IDLE.

Size mapping:
- lb/lbu/sb → 0; lh/lhu/sh → 1; all others → 2.

Store strobes and write data (rt = latched in_rtdata):
- sb: wstrb = 1<<ea; wdata = {4{rt[7:0]}}.
- sh: ea0 → 0011, ea2 → 1100; wdata = {2{rt[15:0]}}.
- sw: 1111; wdata = rt.
- swl:
  - ea0 → 0001, {24'b0,rt[31:24]}
  - ea1 → 0011, {16'b0,rt[31:16]}
  - ea2 → 0111, {8'b0,rt[31:8]}
  - ea3 → 1111, rt
- swr:
  - ea0 → 1111, rt
  - ea1 → 1110, {rt[23:0],8'b0}
  - ea2 → 1100, {rt[15:0],16'b0}
  - ea3 → 1000, {rt[7:0],24'b0}

## Timing
- Reset values (next edge with resetn=0): state IDLE; data_req, data_wr, data_wstrb, out_valid, out_exc, out_is_load = 0; all latched data/opcode/ea/dest registers = 0.
- data_size and data_wdata are 0 while data_req=0.
- Reset mid-access from any state: return to IDLE. data_req drops on that edge, and a late data_data_ok is ignored.
- Minimum latency, addr_ok and data_ok each arriving in their first eligible cycle:
  - accept at edge 0
  - data_req high in cycle 1
  - DATA in cycle 2
  - out_valid in cycle 3
- Misaligned access: out_valid in cycle 1 after accept.
- data_data_ok seen in IDLE/ADDR/RESP is ignored. data_addr_ok seen outside ADDR is ignored.
- At most one outstanding request; in_ready=0 in every state except IDLE.
- RESP with out_ready held low: all out_* are held indefinitely and no new accept occurs.
- RESP→IDLE edge: in_ready becomes 1 the following cycle (no same-cycle back-to-back accept).

## Test plan
- lw addr 0x1000, addr_ok delayed 2 cycles, data_ok 1 cycle later with rdata 0xDEADBEEF → data_req held 3 cycles with data_addr 0x1000/size 2/wr 0; out_valid carries loadin 0xDEADBEEF, ea 0, is_load 1.
- sb addr 0x2003, rt 0x000000A5 → wstrb 1000, wdata 0xA5A5A5A5, size 0, addr 0x2000; out_valid with is_load 0.
- swl addr 0x3001, rt 0x11223344 → wstrb 0011, wdata 0x00001122. Same with swr → wstrb 1110, wdata 0x22334400.
- lh addr 0x4001 → no data_req; out_valid in cycle 1 with out_exc=1. sw addr 0x4002 → out_exc=2.
- lwr accepted, resetn pulsed low in DATA, then data_ok → state IDLE, out_valid stays 0, in_ready=1 after reset.
- out_ready held low 5 cycles in RESP while in_valid=1 → out_* stable, in_ready=0; new accept only one cycle after the out_ready handshake.
